ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_if.sv | 14 +
 rtl/ifetch.sv | 169 ++++++++++++++++
 tb/tb_ifetch.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// Request/acknowledge semantics: the master raises imem_req with a stable
// imem_addr and keeps both unchanged until the slave answers with imem_ack=1;
// imem_rdata is meaningful only in a cycle where imem_ack=1, and that cycle
// completes the request. The slave never acknowledges while imem_req=0.
interface ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: drives the instruction memory, updates the PC
// register and fills the IF/ID pipeline register. Handles memory wait states,
// decode stalls (with a one-entry hold register) and branch redirects
// (an in-flight request is drained and its response discarded).
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module ifetch #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] pc_in,
    output logic        pc_write,
    output logic [31:0] pc_next,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    ifetch_if.master    imem,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_imem_addr;
    logic        r_hold_valid;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_instr;
    logic        r_if_id_valid;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc4;
    logic [31:0] r_if_id_instr;

    logic        w_in_fetch;
    logic [31:0] w_fetch_pc;
    logic        w_mem_word;
    logic        w_hold_rdy;
    logic        w_deliver;
    logic [31:0] w_dlv_pc;
    logic [31:0] w_dlv_pc4;
    logic [31:0] w_dlv_instr;

    // Delivery decision, PC update and memory request for the current cycle.
    // In FETCH the address follows pc_in directly so a zero-wait memory can
    // return one word per cycle; elsewhere the latched address is presented.
    always_comb begin
        w_in_fetch     = (r_state == FETCH);
        w_fetch_pc     = w_in_fetch ? pc_in : r_imem_addr;
        w_mem_word     = !res && (w_in_fetch || (r_state == WAIT)) && imem.imem_ack;
        w_hold_rdy     = !res && (r_state == HOLD) && r_hold_valid;
        w_deliver      = !res && !branch_taken && !stall && (w_mem_word || w_hold_rdy);
        w_dlv_pc       = (r_state == HOLD) ? r_hold_pc : w_fetch_pc;
        w_dlv_instr    = (r_state == HOLD) ? r_hold_instr : imem.imem_rdata;
        w_dlv_pc4      = w_dlv_pc + 32'd4;
        pc_write       = !res && (branch_taken || w_deliver);
        pc_next        = branch_taken ? branch_target : w_dlv_pc4;
        imem.imem_req  = !res && (r_state != HOLD);
        imem.imem_addr = w_fetch_pc;
    end

    // Fetch FSM together with the IF/ID and hold registers it controls.
    // A branch that coincides with the acknowledge of the outstanding request
    // returns straight to FETCH: nothing is left in flight to drain.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state       <= FETCH;
            r_imem_addr   <= 32'd0;
            r_hold_valid  <= 1'b0;
            r_hold_pc     <= 32'd0;
            r_hold_instr  <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= 32'd0;
            r_if_id_pc4   <= 32'd0;
        end else begin
            if (w_in_fetch) begin
                r_imem_addr <= pc_in;
            end

            if (branch_taken || (!w_deliver && !stall)) begin
                r_if_id_valid <= 1'b0;
                r_if_id_instr <= NOP_INSTR;
            end else if (w_deliver) begin
                r_if_id_valid <= 1'b1;
                r_if_id_instr <= w_dlv_instr;
                r_if_id_pc    <= w_dlv_pc;
                r_if_id_pc4   <= w_dlv_pc4;
            end

            if (branch_taken) begin
                r_hold_valid <= 1'b0;
            end

            case (r_state)
                FETCH, WAIT: begin
                    if (branch_taken) begin
                        r_state <= imem.imem_ack ? FETCH : DRAIN;
                    end else if (imem.imem_ack) begin
                        if (stall) begin
                            r_hold_valid <= 1'b1;
                            r_hold_pc    <= w_fetch_pc;
                            r_hold_instr <= imem.imem_rdata;
                            r_state      <= HOLD;
                        end else begin
                            r_state <= FETCH;
                        end
                    end else begin
                        r_state <= WAIT;
                    end
                end
                HOLD: begin
                    if (branch_taken || !stall) begin
                        r_hold_valid <= 1'b0;
                        r_state      <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ack) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    assign if_id_valid = r_if_id_valid;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_instr = r_if_id_instr;
    assign dbg_state   = r_state;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    // Count valid IF/ID loads and stall cycles; both wrap at 2^32.
    always_ff @(posedge clk) begin
        if (res) begin
            r_perf_fetch <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (w_deliver) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_stall = r_perf_stall;
`else
    assign perf_fetch = 32'd0;
    assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: PC register and instruction memory with configurable
// latency live here, plus a transaction-level reference model (outstanding
// request, discard flag, held-word queue) that predicts every output.
module tb_ifetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        res;
    logic [31:0] pc_reg;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_pc4, if_id_instr, perf_fetch, perf_stall;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    ifetch_if imem();

    ifetch #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .res(res), .pc_in(pc_reg), .pc_write(pc_write), .pc_next(pc_next),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .imem(imem), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
        .if_id_instr(if_id_instr), .perf_fetch(perf_fetch), .perf_stall(perf_stall),
        .dbg_state(dbg_state)
    );

    // PC register owned by the environment
    always_ff @(posedge clk) begin
        if (res) pc_reg <= 32'd0;
        else if (pc_write) pc_reg <= pc_next;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    assign imem.imem_rdata = mem_word(imem.imem_addr);

    // ---------------- memory latency state ----------------
    int lat_mode;   // -1 random, otherwise fixed wait cycles
    bit mem_busy;
    int mem_lat;

    function automatic int pick_lat();
        if (lat_mode >= 0) return lat_mode;
        return ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    bit          m_pending, m_discard;
    logic [31:0] m_req_addr;
    logic [63:0] exp_q[$];       // held {pc, instr} waiting for stall to drop
    logic        m_v;
    logic [31:0] m_ipc, m_ipc4, m_instr, m_pf, m_ps;

    // expected / observed for the most recent step
    logic        e_req, e_pcw, a_req, a_pcw, a_v;
    logic [31:0] e_addr, e_pcn, e_pf, e_ps, a_addr, a_pcn, a_ipc, a_ipc4, a_instr, a_pf, a_ps;

    int total = 0;
    int bad = 0;

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        logic        a, hv, resp, keep, dlv;
        logic [63:0] word;
        @(negedge clk);
        res = r; stall = s; branch_taken = b; branch_target = t;
        #1;
        if (imem.imem_req && !mem_busy) begin
            mem_busy = 1'b1;
            mem_lat  = pick_lat();
        end
        a = imem.imem_req && mem_busy && (mem_lat == 0);
        imem.imem_ack = a;
        #1;
        a_req = imem.imem_req; a_addr = imem.imem_addr; a_pcw = pc_write; a_pcn = pc_next;

        hv     = (exp_q.size() != 0);
        e_req  = !r && !hv;
        e_addr = m_pending ? m_req_addr : m_pc;
        resp   = e_req && a;
        keep   = resp && !m_discard;
        word   = hv ? exp_q[0] : {e_addr, mem_word(e_addr)};
        dlv    = !r && !b && !s && (hv || keep);
        e_pcw  = !r && (b || dlv);
        e_pcn  = b ? t : word[63:32] + 32'd4;

        @(posedge clk);
        if (r || a) mem_busy = 1'b0;
        else if (mem_busy && mem_lat > 0) mem_lat--;

        if (r) begin
            m_pc = 32'd0; m_pending = 0; m_discard = 0; exp_q.delete();
            m_v = 1'b0; m_instr = NOP; m_ipc = 32'd0; m_ipc4 = 32'd0; m_pf = 32'd0; m_ps = 32'd0;
        end else begin
            if (e_pcw) m_pc = e_pcn;
            if (b) begin
                m_v = 1'b0; m_instr = NOP; exp_q.delete();
                m_pending = e_req && !a;
                m_discard = m_pending;
                if (m_pending) m_req_addr = e_addr;
            end else begin
                if (dlv) begin
                    m_v = 1'b1; m_ipc = word[63:32]; m_ipc4 = word[63:32] + 32'd4;
                    m_instr = word[31:0]; m_pf = m_pf + 32'd1;
                    if (hv) exp_q.delete();
                end else if (!s) begin
                    m_v = 1'b0; m_instr = NOP;
                end
                if (resp) begin
                    if (keep && s) exp_q.push_back(word);
                    m_pending = 0; m_discard = 0;
                end else if (e_req) begin
                    m_pending = 1; m_req_addr = e_addr;
                end
            end
            if (s) m_ps = m_ps + 32'd1;
        end
        e_pf = PERF ? m_pf : 32'd0;
        e_ps = PERF ? m_ps : 32'd0;
        #1;
        a_v = if_id_valid; a_ipc = if_id_pc; a_ipc4 = if_id_pc4; a_instr = if_id_instr;
        a_pf = perf_fetch; a_ps = perf_stall;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            total++; if (a_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", a_req); end
            total++; if (a_pcw !== 1'b0) begin bad++; $display("FAIL rst_pcw got=%b exp=0", a_pcw); end
        end
        total++; if (a_v !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", a_v); end
        total++; if (a_instr !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", a_instr, NOP); end
        total++; if (a_ipc !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h exp=0", a_ipc); end
        total++; if (a_ipc4 !== 32'd0) begin bad++; $display("FAIL rst_pc4 got=%h exp=0", a_ipc4); end
        total++; if (a_pf !== 32'd0) begin bad++; $display("FAIL rst_perf_fetch got=%h exp=0", a_pf); end
        total++; if (a_ps !== 32'd0) begin bad++; $display("FAIL rst_perf_stall got=%h exp=0", a_ps); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] p;
        lat_mode = 0;
        for (int k = 0; k < 4; k++) begin
            p = 32'(4 * k);
            step(1'b0, 1'b0, 1'b0, 32'd0);
            total++; if (a_addr !== p) begin bad++; $display("FAIL zw_addr k=%0d got=%h exp=%h", k, a_addr, p); end
            total++; if (a_pcw !== 1'b1 || a_pcn !== p + 32'd4) begin bad++; $display("FAIL zw_pcnext k=%0d got=%b/%h exp=1/%h", k, a_pcw, a_pcn, p + 32'd4); end
            total++; if (a_v !== 1'b1 || a_ipc !== p || a_ipc4 !== p + 32'd4) begin bad++; $display("FAIL zw_ifid k=%0d got=%b/%h/%h exp=1/%h/%h", k, a_v, a_ipc, a_ipc4, p, p + 32'd4); end
            total++; if (a_instr !== mem_word(p)) begin bad++; $display("FAIL zw_instr k=%0d got=%h exp=%h", k, a_instr, mem_word(p)); end
        end
    endtask

    task automatic test_delay();
        lat_mode = 0;
        step(1'b0, 1'b0, 1'b1, 32'h40);
        lat_mode = 3;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            total++; if (a_req !== 1'b1 || a_addr !== 32'h40) begin bad++; $display("FAIL dly_addr k=%0d got=%b/%h exp=1/00000040", k, a_req, a_addr); end
            total++; if (a_pcw !== 1'b0) begin bad++; $display("FAIL dly_pcw k=%0d got=%b exp=0", k, a_pcw); end
            total++; if (a_v !== 1'b0) begin bad++; $display("FAIL dly_bubble k=%0d got=%b exp=0", k, a_v); end
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (a_pcw !== 1'b1 || a_pcn !== 32'h44) begin bad++; $display("FAIL dly_pcnext got=%b/%h exp=1/00000044", a_pcw, a_pcn); end
        total++; if (a_v !== 1'b1 || a_ipc !== 32'h40) begin bad++; $display("FAIL dly_ifid got=%b/%h exp=1/00000040", a_v, a_ipc); end
    endtask

    task automatic test_stall_hold();
        lat_mode = 0;
        step(1'b0, 1'b0, 1'b1, 32'h0C);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0);
            total++; if (a_pcw !== 1'b0) begin bad++; $display("FAIL hold_pcw k=%0d got=%b exp=0", k, a_pcw); end
            total++; if (a_v !== 1'b1 || a_ipc !== 32'h0C || a_instr !== mem_word(32'h0C)) begin bad++; $display("FAIL hold_ifid k=%0d got=%b/%h/%h exp=1/0000000c/%h", k, a_v, a_ipc, a_instr, mem_word(32'h0C)); end
        end
        total++; if (a_req !== 1'b0) begin bad++; $display("FAIL hold_req got=%b exp=0", a_req); end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (a_pcw !== 1'b1 || a_pcn !== 32'h14) begin bad++; $display("FAIL hold_pcnext got=%b/%h exp=1/00000014", a_pcw, a_pcn); end
        total++; if (a_v !== 1'b1 || a_ipc !== 32'h10 || a_instr !== mem_word(32'h10)) begin bad++; $display("FAIL hold_release got=%b/%h/%h exp=1/00000010/%h", a_v, a_ipc, a_instr, mem_word(32'h10)); end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (a_addr !== 32'h14) begin bad++; $display("FAIL hold_next_addr got=%h exp=00000014", a_addr); end
    endtask

    task automatic test_branch_wait();
        lat_mode = 0;
        step(1'b0, 1'b0, 1'b1, 32'h80);
        lat_mode = 2;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (a_addr !== 32'h80 || a_pcw !== 1'b0) begin bad++; $display("FAIL brw_wait got=%h/%b exp=00000080/0", a_addr, a_pcw); end
        step(1'b0, 1'b0, 1'b1, 32'h200);
        total++; if (a_pcw !== 1'b1 || a_pcn !== 32'h200) begin bad++; $display("FAIL brw_pcnext got=%b/%h exp=1/00000200", a_pcw, a_pcn); end
        total++; if (a_v !== 1'b0 || a_instr !== NOP) begin bad++; $display("FAIL brw_bubble got=%b/%h exp=0/%h", a_v, a_instr, NOP); end
        lat_mode = 0;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (a_req !== 1'b1 || a_addr !== 32'h80 || a_pcw !== 1'b0) begin bad++; $display("FAIL brw_drain got=%b/%h/%b exp=1/00000080/0", a_req, a_addr, a_pcw); end
        total++; if (a_v !== 1'b0) begin bad++; $display("FAIL brw_discard got=%b exp=0", a_v); end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (a_addr !== 32'h200 || a_pcn !== 32'h204) begin bad++; $display("FAIL brw_refetch got=%h/%h exp=00000200/00000204", a_addr, a_pcn); end
        total++; if (a_v !== 1'b1 || a_ipc !== 32'h200) begin bad++; $display("FAIL brw_ifid got=%b/%h exp=1/00000200", a_v, a_ipc); end
    endtask

    task automatic test_reset_in_wait();
        lat_mode = 3;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        total++; if (a_req !== 1'b0 || a_pcw !== 1'b0) begin bad++; $display("FAIL rw_during got=%b/%b exp=0/0", a_req, a_pcw); end
        total++; if (a_v !== 1'b0 || a_instr !== NOP) begin bad++; $display("FAIL rw_ifid got=%b/%h exp=0/%h", a_v, a_instr, NOP); end
        lat_mode = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            if (k == 0) begin
                total++; if (a_req !== 1'b1 || a_addr !== 32'd0) begin bad++; $display("FAIL rw_fetch got=%b/%h exp=1/00000000", a_req, a_addr); end
            end
        end
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        total++; if (a_pf !== (PERF ? 32'd5 : 32'd0)) begin bad++; $display("FAIL rw_perf_fetch got=%0d exp=%0d", a_pf, PERF ? 5 : 0); end
        total++; if (a_ps !== (PERF ? 32'd2 : 32'd0)) begin bad++; $display("FAIL rw_perf_stall got=%0d exp=%0d", a_ps, PERF ? 2 : 0); end
    endtask

    task automatic test_wrap();
        lat_mode = 0;
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (a_pcw !== 1'b1 || a_pcn !== 32'd0) begin bad++; $display("FAIL wrap_pcnext got=%b/%h exp=1/00000000", a_pcw, a_pcn); end
        total++; if (a_ipc !== 32'hFFFF_FFFC || a_ipc4 !== 32'd0) begin bad++; $display("FAIL wrap_pc4 got=%h/%h exp=fffffffc/00000000", a_ipc, a_ipc4); end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (a_addr !== 32'd0) begin bad++; $display("FAIL wrap_addr got=%h exp=00000000", a_addr); end
    endtask

    task automatic test_random();
        logic        r, s, b;
        logic [31:0] t;
        lat_mode = -1;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
            step(r, s, b, t);
            total++; if (a_req !== e_req) begin bad++; $display("FAIL rnd_req i=%0d got=%b exp=%b", i, a_req, e_req); end
            if (!r) begin
                total++; if (a_addr !== e_addr) begin bad++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, a_addr, e_addr); end
            end
            total++; if (a_pcw !== e_pcw) begin bad++; $display("FAIL rnd_pcw i=%0d got=%b exp=%b", i, a_pcw, e_pcw); end
            if (e_pcw) begin
                total++; if (a_pcn !== e_pcn) begin bad++; $display("FAIL rnd_pcnext i=%0d got=%h exp=%h", i, a_pcn, e_pcn); end
            end
            total++; if (a_v !== m_v) begin bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, a_v, m_v); end
            total++; if (a_instr !== m_instr) begin bad++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, a_instr, m_instr); end
            total++; if (a_ipc !== m_ipc || a_ipc4 !== m_ipc4) begin bad++; $display("FAIL rnd_pc i=%0d got=%h/%h exp=%h/%h", i, a_ipc, a_ipc4, m_ipc, m_ipc4); end
            total++; if (a_pf !== e_pf || a_ps !== e_ps) begin bad++; $display("FAIL rnd_perf i=%0d got=%0d/%0d exp=%0d/%0d", i, a_pf, a_ps, e_pf, e_ps); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        res = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        imem.imem_ack = 1'b0;
        lat_mode = 0; mem_busy = 1'b0; mem_lat = 0;
        m_pc = 32'd0; m_pending = 0; m_discard = 0; m_req_addr = 32'd0;
        m_v = 1'b0; m_ipc = 32'd0; m_ipc4 = 32'd0; m_instr = NOP; m_pf = 32'd0; m_ps = 32'd0;
        test_reset();
        test_zero_wait();
        test_delay();
        test_stall_hold();
        test_branch_wait();
        test_reset_in_wait();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
